// File: rtl/timer_tick_mc.sv
// timer_tick_mc: multi-channel tick timer with a small register interface.
// Each channel has CONTROL/PERIOD/COUNTER/INFO registers, a counter with four
// modes and a sticky interrupt-pending bit.
// Optional per-channel prescaler: define TIMER_TICK_MC_PRESCALER_EN.
module timer_tick_mc #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned FREQUENCY = 1_000_000
) (
  input  logic              clk_i,
  input  logic              rstb_i,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [4:0]        addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic [NUM_CH-1:0] ip_o,
  output logic              intr_o
);

  localparam logic [1:0] RegCtrl    = 2'd0;
  localparam logic [1:0] RegPeriod  = 2'd1;
  localparam logic [1:0] RegCounter = 2'd2;

  localparam logic [1:0] ModeOff     = 2'd0;
  localparam logic [1:0] ModeRestart = 2'd1;
  localparam logic [1:0] ModeOneShot = 2'd2;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        mode_q    [NUM_CH];
  logic [1:0]        mode_d    [NUM_CH];
  logic [CNT_W-1:0]  period_q  [NUM_CH];
  logic [CNT_W-1:0]  period_d  [NUM_CH];
  logic [CNT_W-1:0]  counter_q [NUM_CH];
  logic [CNT_W-1:0]  counter_d [NUM_CH];
  logic [NUM_CH-1:0] ie_q, ie_d;
  logic [NUM_CH-1:0] ip_q, ip_d;
  // Marks that a one-shot channel has already signalled its match.
  logic [NUM_CH-1:0] fired_q, fired_d;

`ifdef TIMER_TICK_MC_PRESCALER_EN
  logic [7:0]        prescale_q [NUM_CH];
  logic [7:0]        prescale_d [NUM_CH];
  logic [7:0]        presc_q    [NUM_CH];
  logic [7:0]        presc_d    [NUM_CH];
`endif

  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_period;
  logic [NUM_CH-1:0] wr_counter;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] hw_set;
  logic [NUM_CH-1:0] ip_sw;

  // Not every data_i bit lands in a register in every configuration.
  logic unused_data;
  assign unused_data = ^data_i;

  // Decode the channel index and per-register write strobes.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel[i]     = (addr_i[4:2] == 3'(i));
      wr_ctrl[i]    = we_i && ch_sel[i] && (addr_i[1:0] == RegCtrl);
      wr_period[i]  = we_i && ch_sel[i] && (addr_i[1:0] == RegPeriod);
      wr_counter[i] = we_i && ch_sel[i] && (addr_i[1:0] == RegCounter);
    end
  end

  // Tick on every enabled cycle, or every (PRESCALE+1)th one with the prescaler.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      match[i] = (counter_q[i] == period_q[i]);
`ifdef TIMER_TICK_MC_PRESCALER_EN
      // >= keeps the prescaler from running long if PRESCALE is lowered mid-count.
      tick[i]  = (mode_q[i] != ModeOff) && (presc_q[i] >= prescale_q[i]);
`else
      tick[i]  = (mode_q[i] != ModeOff);
`endif
    end
  end

  // Next-state: tick-driven counter update first, then register writes override.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i]    = mode_q[i];
      ie_d[i]      = ie_q[i];
      period_d[i]  = period_q[i];
      counter_d[i] = counter_q[i];
      fired_d[i]   = fired_q[i];
      ip_sw[i]     = ip_q[i];
`ifdef TIMER_TICK_MC_PRESCALER_EN
      prescale_d[i] = prescale_q[i];
      if (mode_q[i] == ModeOff || tick[i]) begin
        presc_d[i] = 8'd0;
      end else begin
        presc_d[i] = presc_q[i] + 8'd1;
      end
`endif

      // A held one-shot keeps matching; only the first match may raise ip.
      hw_set[i] = tick[i] && match[i] && ie_q[i] &&
                  !((mode_q[i] == ModeOneShot) && fired_q[i]);
      if (tick[i] && match[i] && (mode_q[i] == ModeOneShot)) begin
        fired_d[i] = 1'b1;
      end

      if (mode_q[i] == ModeOff) begin
        counter_d[i] = CntOne;
      end else if (tick[i]) begin
        case (mode_q[i])
          ModeRestart: counter_d[i] = match[i] ? CntOne : counter_q[i] + CntOne;
          ModeOneShot: counter_d[i] = match[i] ? counter_q[i] : counter_q[i] + CntOne;
          default:     counter_d[i] = counter_q[i] + CntOne;
        endcase
      end

      if (wr_ctrl[i]) begin
        mode_d[i] = data_i[1:0];
        ie_d[i]   = data_i[2];
        if (!data_i[3]) begin
          ip_sw[i] = 1'b0;
        end
        if (data_i[1:0] != mode_q[i]) begin
          fired_d[i] = 1'b0;
`ifdef TIMER_TICK_MC_PRESCALER_EN
          presc_d[i] = 8'd0;
`endif
        end
`ifdef TIMER_TICK_MC_PRESCALER_EN
        prescale_d[i] = data_i[15:8];
`endif
      end

      if (wr_period[i]) begin
        period_d[i] = data_i[CNT_W-1:0];
        fired_d[i]  = 1'b0;
      end

      if (wr_counter[i]) begin
        counter_d[i] = data_i[CNT_W-1:0];
        fired_d[i]   = 1'b0;
`ifdef TIMER_TICK_MC_PRESCALER_EN
        presc_d[i]   = 8'd0;
`endif
      end

      // Hardware set beats software clear; a disabled interrupt never pends.
      ip_d[i] = (ip_sw[i] || hw_set[i]) && ie_d[i];
    end
  end

  // Register read mux; idle or out-of-range reads return zero.
  always_comb begin
    data_o = '0;
    if (re_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_sel[i]) begin
          case (addr_i[1:0])
            RegCtrl: begin
              data_o = {28'h0, ip_q[i], ie_q[i], mode_q[i]};
`ifdef TIMER_TICK_MC_PRESCALER_EN
              data_o[15:8] = prescale_q[i];
`endif
            end
            RegPeriod:  data_o[CNT_W-1:0] = period_q[i];
            RegCounter: data_o[CNT_W-1:0] = counter_q[i];
            default:    data_o = FREQUENCY;
          endcase
        end
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      ie_q    <= '0;
      ip_q    <= '0;
      fired_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]     <= ModeOff;
        period_q[i]   <= '0;
        counter_q[i]  <= CntOne;
`ifdef TIMER_TICK_MC_PRESCALER_EN
        prescale_q[i] <= 8'd0;
        presc_q[i]    <= 8'd0;
`endif
      end
    end else begin
      ie_q    <= ie_d;
      ip_q    <= ip_d;
      fired_q <= fired_d;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]     <= mode_d[i];
        period_q[i]   <= period_d[i];
        counter_q[i]  <= counter_d[i];
`ifdef TIMER_TICK_MC_PRESCALER_EN
        prescale_q[i] <= prescale_d[i];
        presc_q[i]    <= presc_d[i];
`endif
      end
    end
  end

  assign ip_o   = ip_q;
  assign intr_o = |ip_q;

endmodule

// File: doc/timer_tick_mc.md
TIMER_TICK_MC -- requirements
Module: timer_tick_mc

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, number of independent timer channels, legal range 1..8.
REQ-002 The block SHALL have parameter CNT_W, default 32, counter and period width, legal range 8..32.
REQ-003 The block SHALL have parameter FREQUENCY, default 1_000_000, the clk_i frequency in Hz, returned on register reads.
REQ-004 The block SHALL have port clk_i, input, 1 bit: clock. All logic is on this single domain.
REQ-005 The block SHALL have port rstb_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port re_i, input, 1 bit: register read strobe.
REQ-007 The block SHALL have port we_i, input, 1 bit: register write strobe.
REQ-008 The block SHALL have port addr_i, input, 5 bits: [4:2] channel index, [1:0] register select.
REQ-009 The block SHALL have port data_i, input, 32 bits: write data.
REQ-010 The block SHALL have port data_o, output, 32 bits: read data, combinational from re_i and addr_i.
REQ-011 The block SHALL have port ip_o, output, NUM_CH bits: per-channel interrupt pending.
REQ-012 The block SHALL have port intr_o, output, 1 bit: OR of all ip_o bits.

Function
REQ-013 The per-channel registers SHALL be: 00 CONTROL {16'h0, PRESCALE[7:0], 4'h0, ip, ie, mode[1:0]}; 01 PERIOD; 10 COUNTER; 11 INFO (read-only).
- Reads of INFO SHALL return FREQUENCY.
- PERIOD and COUNTER SHALL be zero-extended to 32 bits on read.
- Writes to PERIOD and COUNTER SHALL use data_i[CNT_W-1:0].
REQ-014 When re_i=0, or the channel index is >= NUM_CH, data_o SHALL be 0; writes to a channel index >= NUM_CH SHALL be ignored.
REQ-015 A register write SHALL take effect on the next clk_i edge; a read in the following cycle SHALL return the new value.
REQ-016 Each channel SHALL have a prescaler that generates a tick on every (PRESCALE+1)th clk_i cycle. PRESCALE=0 gives a tick every cycle.
REQ-017 On each tick, the counter SHALL update according to mode:
- 00 (disable): counter held at 1 on every cycle, prescaler held at 0, no ticks.
- 01 (restart): if COUNTER==PERIOD, load 1; else increment.
- 10 (one-shot): if COUNTER==PERIOD, hold; else increment.
- 11 (continuous): increment, wrapping from 2^CNT_W-1 to 0.
REQ-018 ip SHALL be set on a tick where COUNTER==PERIOD before the update and ie=1. In one-shot mode the hold state SHALL set ip only once, on the first matching tick.
REQ-019 ip SHALL be cleared by a CONTROL write with data_i[3]=0. Writing data_i[3]=1 SHALL leave ip unchanged.
REQ-020 If a hardware set and a software clear of ip occur in the same cycle, the set SHALL win.
REQ-021 While ie=0, ip SHALL be 0 and SHALL NOT be set.
REQ-022 A COUNTER write SHALL override any tick update in that cycle, and SHALL reset that channel's prescaler to 0.
REQ-023 A CONTROL write that changes mode SHALL reset that channel's prescaler. The first tick in the new mode SHALL occur PRESCALE+1 cycles after the write.
REQ-024 Channels SHALL be fully independent; a write to one channel SHALL NOT affect any other channel's state.
REQ-025 PERIOD=0 SHALL match only a counter value of 0, which is reachable only in continuous wrap or by a COUNTER write.

Reset
REQ-026 While rstb_i=0, every channel SHALL have: mode=00, ie=0, ip=0, PRESCALE=0, PERIOD=0, COUNTER=1, prescaler=0.
- ip_o and intr_o SHALL be 0.
- This SHALL hold when reset is asserted mid-count.
REQ-027 After rstb_i deasserts, no channel SHALL count until mode is written to a non-zero value.

Configuration
REQ-028 With macro TIMER_TICK_MC_PRESCALER_EN defined, the prescaler of REQ-016 SHALL be present.
REQ-029 Without TIMER_TICK_MC_PRESCALER_EN:
- Every enabled clk_i cycle SHALL be a tick.
- CONTROL[15:8] SHALL read 0, and writes to it SHALL be ignored.
- No prescaler flops SHALL be synthesised.

Verification
REQ-030 Restart mode: ch0 PERIOD=3, CONTROL=0x0000_0005 (ie=1, mode=01) -> COUNTER sequence 1,2,3,1,2,3; ip_o[0] rises on the tick where COUNTER=3 and stays high.
REQ-031 One-shot mode: ch1 PERIOD=5, mode=10, ie=1 -> COUNTER stops at 5 and ip_o[1] sets once. After writing CONTROL=0x6, ip stays 0 while COUNTER holds at 5.
REQ-032 Prescaler (macro defined): ch2 PRESCALE=3, PERIOD=2, mode=01, ie=1 -> COUNTER advances every 4 cycles; ip sets 8 cycles after the CONTROL write.
REQ-033 Wrap and simultaneity:
- CNT_W=8, ch3 COUNTER=0xFE, mode=11 -> COUNTER sequence 0xFE, 0xFF, 0x00, 0x01.
- Software ip clear issued on the same cycle as a match -> ip remains 1.
REQ-034 Isolation and reset: all four channels running; write ch1 COUNTER=0x10 -> ch0, ch2 and ch3 are unchanged. Assert rstb_i mid-count -> every COUNTER reads 1, intr_o=0, and INFO reads 1_000_000.
